// File: rtl/codecracker_switch_scanner.sv
// Switch scanner: periodically reads the switch PIO over Avalon-MM, debounces the value,
// latches per-bit change flags and raises a maskable level interrupt.
module codecracker_switch_scanner #(
  parameter int WIDTH      = 10,
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DEB_MAX  = 4'(DEBOUNCE_N);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, UPDATE} state_t;

  state_t           state;
  logic [DIV_W-1:0] period;
  logic             enable;
  logic             pending;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] cand;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] mask;

  logic             wr_edge, wr_mask, wr_ctrl, force_req, tick;
  logic [3:0]       cnt_next;
  logic             accept;
  logic [WIDTH-1:0] edge_set;
  logic             unused_bits;

  assign wr_edge   = s_write && (s_address == 2'd1);
  assign wr_mask   = s_write && (s_address == 2'd2);
  assign wr_ctrl   = s_write && (s_address == 2'd3);
  assign force_req = wr_ctrl && s_writedata[1];
  assign tick      = enable && (period == DIV_LAST);
  assign m_address = 2'd0;
  assign irq       = |(edges & mask);
  assign unused_bits = ^{m_readdata[31:WIDTH], s_writedata[31:WIDTH]};

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    cnt_next = 4'd1;
    if (sample == cand)
      cnt_next = (cnt >= DEB_MAX) ? DEB_MAX : cnt + 4'd1;
    accept   = (state == UPDATE) && (cnt_next == DEB_MAX) && (sample != stable);
    edge_set = accept ? (sample ^ stable) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments and the async active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
    end else if (!enable || tick) begin
      period <= '0;
    end else begin
      period <= period + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      m_read  <= 1'b0;
      pending <= 1'b0;
      sample  <= '0;
      cand    <= '0;
      cnt     <= 4'd0;
      stable  <= '0;
    end else begin
      m_read <= 1'b0;
      case (state)
        IDLE: begin
          if (tick || pending || force_req) begin
            state   <= REQ;
            m_read  <= 1'b1;
            pending <= 1'b0;
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          sample <= m_readdata[WIDTH-1:0];
          state  <= UPDATE;
        end
        UPDATE: begin
          cand  <= sample;
          cnt   <= cnt_next;
          if (accept) stable <= sample;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A FORCE arriving mid-scan is remembered once and served on the next IDLE cycle.
      if (force_req && (state != IDLE)) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edges  <= '0;
      mask   <= '0;
      enable <= 1'b1;
    end else begin
      // Set from a debounce update wins over a simultaneous write-1-to-clear.
      edges <= (edges & ~(wr_edge ? s_writedata[WIDTH-1:0] : '0)) | edge_set;
      if (wr_mask) mask <= s_writedata[WIDTH-1:0];
      if (wr_ctrl) enable <= s_writedata[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= 32'd0;
    end else if (s_read) begin
      case (s_address)
        2'd0:    s_readdata <= 32'(stable);
        2'd1:    s_readdata <= 32'(edges);
        2'd2:    s_readdata <= 32'(mask);
        default: s_readdata <= {24'd0, cnt, 3'd0, enable};
      endcase
    end
  end

endmodule

// File: tb/tb_codecracker_switch_scanner.sv
// Self-checking bench for codecracker_switch_scanner: directed scenarios plus randomized
// forced scans, checked against a history-based debounce reference model.
module tb_codecracker_switch_scanner;

  localparam int DIV = 8;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata = 32'd0;
  logic [1:0]  s_address = 2'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic        irq;

  codecracker_switch_scanner #(.WIDTH(10), .SCAN_DIV(DIV), .DEBOUNCE_N(DEB)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_read(m_read), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Switch PIO model: registered readdata, junk in the unused upper bits.
  logic [9:0]  sw = 10'd0;
  logic [21:0] junk = 22'd0;
  always @(posedge clk) m_readdata <= {junk, sw};

  int pulses = 0;
  always @(negedge clk) if (m_read === 1'b1) pulses <= pulses + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: STATE follows the switches once the last DEB scans agree.
  logic [9:0] hist[$];
  logic [9:0] exp_state, exp_edge, exp_mask;
  logic       exp_en;

  function automatic void model_scan(input logic [9:0] v);
    bit steady = 1'b1;
    hist.push_back(v);
    if (hist.size() > 16) void'(hist.pop_front());
    if (hist.size() < DEB) steady = 1'b0;
    else for (int k = 1; k <= DEB; k++) if (hist[hist.size()-k] != v) steady = 1'b0;
    if (steady && (v != exp_state)) begin
      exp_edge  = exp_edge | (v ^ exp_state);
      exp_state = v;
    end
  endfunction

  function automatic int model_run();
    int r = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] == hist[hist.size()-1]) r++;
      else break;
    end
    return (r > DEB) ? DEB : r;
  endfunction

  function automatic logic [31:0] exp_ctrl();
    return {24'd0, 4'(model_run()), 3'd0, exp_en};
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0; s_read = 1'b0; s_write = 1'b0;
    repeat (3) @(posedge clk);
    hist.delete();
    exp_state = '0; exp_edge = '0; exp_mask = '0; exp_en = 1'b1;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic sread(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); s_address = a; s_read = 1'b1;
    @(posedge clk); #1; d = s_readdata; s_read = 1'b0;
  endtask

  task automatic swrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); s_address = a; s_writedata = d; s_write = 1'b1;
    @(posedge clk); #1; s_write = 1'b0;
    case (a)
      2'd1:    exp_edge = exp_edge & ~d[9:0];
      2'd2:    exp_mask = d[9:0];
      2'd3:    exp_en = d[0];
      default: ;
    endcase
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_read === 1'b1) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL scan_start: no m_read within 40 cycles"); end
  endtask

  // Called in the REQ cycle; optional W1C lands exactly in the UPDATE cycle.
  task automatic finish_scan(input logic [9:0] v, input logic [9:0] w1c);
    logic        pre_irq;
    logic [31:0] rd;
    pre_irq = |(exp_edge & exp_mask);
    @(posedge clk); #1;
    n_cmp++;
    if (m_read !== 1'b0) begin n_bad++; $display("FAIL m_read_width: got %b want 0", m_read); end
    @(posedge clk); #1;
    n_cmp++;
    if (irq !== pre_irq) begin n_bad++; $display("FAIL irq_in_update: got %b want %b", irq, pre_irq); end
    if (w1c != 10'd0) begin
      @(negedge clk); s_address = 2'd1; s_writedata = 32'(w1c); s_write = 1'b1;
      @(posedge clk); #1; s_write = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    exp_edge = exp_edge & ~w1c;
    model_scan(v);
    n_cmp++;
    if (irq !== |(exp_edge & exp_mask)) begin
      n_bad++; $display("FAIL irq_after_update: got %b want %b", irq, |(exp_edge & exp_mask));
    end
    sread(2'd0, rd);
    n_cmp++;
    if (rd !== 32'(exp_state)) begin n_bad++; $display("FAIL state: got %h want %h", rd, 32'(exp_state)); end
    sread(2'd1, rd);
    n_cmp++;
    if (rd !== 32'(exp_edge)) begin n_bad++; $display("FAIL edge: got %h want %h", rd, 32'(exp_edge)); end
    sread(2'd3, rd);
    n_cmp++;
    if (rd !== exp_ctrl()) begin n_bad++; $display("FAIL ctrl: got %h want %h", rd, exp_ctrl()); end
  endtask

  task automatic run_scan(input logic [9:0] v, input bit use_force, input logic [9:0] w1c);
    bit ok;
    sw = v; junk = 22'($urandom);
    if (use_force) swrite(2'd3, {30'd0, 1'b1, exp_en});
    wait_req(ok);
    if (ok) finish_scan(v, w1c);
  endtask

  task automatic test_reset();
    int first = -1;
    sw = 10'h3FF;
    apply_reset();
    #1;
    n_cmp++;
    if ({m_read, m_address, irq, s_readdata} !== 36'd0) begin
      n_bad++; $display("FAIL reset_outputs: got m_read=%b m_address=%h irq=%b s_readdata=%h want all 0",
                        m_read, m_address, irq, s_readdata);
    end
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (m_read === 1'b1) begin first = i; break; end
    end
    n_cmp++;
    if (first != DIV) begin n_bad++; $display("FAIL first_scan_delay: got %0d want %0d", first, DIV); end
    if (first > 0) begin
      finish_scan(10'h3FF, 10'd0);
      run_scan(10'h3FF, 1'b0, 10'd0);
      run_scan(10'h3FF, 1'b0, 10'd0);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? 10'h001 : 10'h000, 1'b0, 10'd0);
    for (int i = 0; i < 3; i++) run_scan(10'h001, 1'b0, 10'd0);
  endtask

  task automatic test_irq_w1c();
    logic [31:0] rd;
    logic [9:0]  old_mask;
    swrite(2'd3, 32'd0);
    swrite(2'd1, 32'h3FF);
    old_mask = exp_mask;
    @(negedge clk); s_address = 2'd2; s_writedata = 32'h1; s_read = 1'b1; s_write = 1'b1;
    @(posedge clk); #1; rd = s_readdata; s_read = 1'b0; s_write = 1'b0;
    exp_mask = 10'h001;
    n_cmp++;
    if (rd !== 32'(old_mask)) begin n_bad++; $display("FAIL read_during_write: got %h want %h", rd, 32'(old_mask)); end
    sread(2'd2, rd);
    n_cmp++;
    if (rd !== 32'(exp_mask)) begin n_bad++; $display("FAIL mask_readback: got %h want %h", rd, 32'(exp_mask)); end
    for (int i = 0; i < 3; i++) run_scan(10'h000, 1'b1, 10'd0);
    swrite(2'd1, 32'h2);
    n_cmp++;
    if (irq !== |(exp_edge & exp_mask)) begin n_bad++; $display("FAIL irq_other_w1c: got %b want %b", irq, |(exp_edge & exp_mask)); end
    swrite(2'd1, 32'h1);
    n_cmp++;
    if (irq !== |(exp_edge & exp_mask)) begin n_bad++; $display("FAIL irq_w1c_clear: got %b want %b", irq, |(exp_edge & exp_mask)); end
  endtask

  task automatic test_collision();
    swrite(2'd2, 32'h008);
    run_scan(10'h008, 1'b1, 10'd0);
    run_scan(10'h008, 1'b1, 10'd0);
    run_scan(10'h008, 1'b1, 10'h3FF);
  endtask

  task automatic test_force();
    int          base;
    logic [31:0] rd;
    sw = 10'h3C0;
    base = pulses;
    swrite(2'd3, 32'h2);
    swrite(2'd3, 32'h2);
    swrite(2'd3, 32'h2);
    repeat (40) @(posedge clk);
    #1;
    n_cmp++;
    if (pulses - base != 2) begin n_bad++; $display("FAIL force_pulses: got %0d want 2", pulses - base); end
    model_scan(sw);
    model_scan(sw);
    sread(2'd0, rd);
    n_cmp++;
    if (rd !== 32'(exp_state)) begin n_bad++; $display("FAIL force_state: got %h want %h", rd, 32'(exp_state)); end
    sread(2'd3, rd);
    n_cmp++;
    if (rd !== exp_ctrl()) begin n_bad++; $display("FAIL force_ctrl: got %h want %h", rd, exp_ctrl()); end
  endtask

  task automatic test_random();
    logic [9:0] a, b, v, w;
    a = 10'($urandom); b = 10'($urandom);
    swrite(2'd2, 32'($urandom) & 32'h3FF);
    for (int i = 0; i < 30; i++) begin
      if (i % 8 == 0) begin a = 10'($urandom); b = 10'($urandom); end
      if ($urandom_range(0, 4) == 0) swrite(2'd2, 32'($urandom) & 32'h3FF);
      if ($urandom_range(0, 4) == 0) swrite(2'd1, 32'($urandom));
      v = ($urandom_range(0, 3) == 0) ? b : a;
      w = ($urandom_range(0, 4) == 0) ? 10'($urandom) : 10'd0;
      run_scan(v, 1'b1, w);
    end
  endtask

  task automatic test_disable_mid_scan();
    bit          ok;
    int          base;
    logic [31:0] rd;
    sw = 10'h155; junk = 22'($urandom);
    swrite(2'd3, 32'h1);
    wait_req(ok);
    if (ok) begin
      @(posedge clk);
      swrite(2'd3, 32'h0);
      @(posedge clk); #1;
      model_scan(sw);
      base = pulses;
      repeat (4 * DIV) @(posedge clk);
      #1;
      n_cmp++;
      if (pulses != base) begin n_bad++; $display("FAIL disabled_scans: got %0d want 0", pulses - base); end
      sread(2'd0, rd);
      n_cmp++;
      if (rd !== 32'(exp_state)) begin n_bad++; $display("FAIL disable_state: got %h want %h", rd, 32'(exp_state)); end
      sread(2'd3, rd);
      n_cmp++;
      if (rd !== exp_ctrl()) begin n_bad++; $display("FAIL disable_ctrl: got %h want %h", rd, exp_ctrl()); end
    end
    swrite(2'd3, 32'h2);
    n_cmp++;
    if (m_read !== 1'b1) begin n_bad++; $display("FAIL force_req: got %b want 1", m_read); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_read, irq} !== 2'b00) begin n_bad++; $display("FAIL async_reset: got m_read=%b irq=%b want 0 0", m_read, irq); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_irq_w1c();
    test_collision();
    test_force();
    test_random();
    test_disable_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/codecracker_switch_scanner.md
# codecracker_switch_scanner

Avalon-MM controller that owns the 10-bit switch PIO in the CodeCracker system: it periodically issues reads to the PIO, debounces the sampled value, latches per-bit change events and raises an interrupt. The CPU reads a clean, debounced switch state and edge flags through a small slave register file instead of polling the raw PIO.

## Interface
- WIDTH, 10, number of switch bits taken from PIO readdata[WIDTH-1:0]
- SCAN_DIV, 50000, clk cycles between scans (>= 4)
- DEBOUNCE_N, 4, consecutive equal samples required to accept a new value (1..15)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m_address  out  2  master address to switch PIO; always 0
- m_read  out  1  master read strobe to switch PIO
- m_readdata  in  32  switch PIO readdata; fixed read latency 1
- s_address  in  2  slave register select
- s_read  in  1  slave read strobe
- s_write  in  1  slave write strobe
- s_writedata  in  32  slave write data
- s_readdata  out  32  slave read data, read latency 1
- irq  out  1  level interrupt, high while any unmasked edge flag set

## Operation
- Registers (unused upper bits read 0, writes ignored):
  - 0 STATE: debounced value [WIDTH-1:0], read-only.
  - 1 EDGE: sticky change flags; write 1 clears bit, write 0 no effect.
  - 2 MASK: irq enable per bit, RW.
  - 3 CTRL: bit0 ENABLE (RW), bit1 FORCE (write 1 requests one scan; reads 0), bits[7:4] debounce count (RO).
- Period counter runs only while ENABLE=1; counts 0..SCAN_DIV-1, tick on terminal value, then wraps to 0. ENABLE=0 clears counter.
- FSM: IDLE -> REQ on tick or pending FORCE; REQ (m_read=1 one cycle) -> WAIT (capture m_readdata[WIDTH-1:0] into sample) -> UPDATE -> IDLE.
- FORCE while not IDLE sets a pending flag; served on next IDLE cycle; multiple FORCEs collapse to one. Tick during busy scan is dropped.
- Debounce in UPDATE: if sample == cand, cnt <= min(cnt+1, DEBOUNCE_N); else cand <= sample, cnt <= 1. When resulting cnt == DEBOUNCE_N and cand != STATE: STATE <= cand, EDGE <= EDGE | (cand ^ STATE).
- irq = |(EDGE & MASK).
- ENABLE cleared mid-scan: current scan completes; no new tick.

## Timing
- Reset values: m_read 0, m_address 0, s_readdata 0, irq 0, STATE 0, cand 0, cnt 0, EDGE 0, MASK 0, CTRL.ENABLE 1, pending 0, counter 0, FSM IDLE.
- Tick at cycle T -> REQ at T+1 (m_read high), WAIT at T+2, UPDATE at T+3, STATE/EDGE new at T+4, irq reflects at T+4.
- Slave read at cycle T: s_readdata valid T+1, holds until next read.
- Slave write to EDGE in same cycle as UPDATE sets a bit: set wins for that bit; other written bits clear.
- Write and read same cycle to same register: read returns pre-write value.
- Change on switches accepted after DEBOUNCE_N scans; worst case latency DEBOUNCE_N*SCAN_DIV+4 cycles.
- Reset asserted mid-scan: FSM returns to IDLE immediately, m_read drops asynchronously.

## Test plan
- Reset with SCAN_DIV=8, DEBOUNCE_N=3, m_readdata=0x3FF: after reset all outputs 0; first m_read pulse 8 cycles after release; STATE=0x3FF after 3rd scan's UPDATE, EDGE=0x3FF, irq=0 (MASK=0).
- Bounce: switches alternate 0x001/0x000 each scan for 6 scans then hold 0x001 -> STATE stays 0 until 3 consecutive 0x001 scans, then STATE=0x001, EDGE=0x001.
- IRQ/W1C: MASK=0x001, edge on bit0 -> irq=1 at UPDATE+1; write EDGE=0x001 -> irq 0 next cycle; write EDGE=0x002 leaves bit0 set.
- Collision: W1C of bit3 in the exact UPDATE cycle that sets bit3 -> EDGE bit3 remains 1, irq remains high if masked.
- FORCE: ENABLE=0, write CTRL=0x2 three times during one scan -> exactly two m_read pulses total (one immediate, one pending); counter stays 0.
- Disable mid-scan: clear ENABLE in WAIT cycle -> UPDATE still occurs, no further m_read for 4*SCAN_DIV cycles; reset asserted during REQ -> m_read 0 same cycle.
